// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int unsigned M0 = 0;
    localparam int unsigned M1 = 1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the two masters.
// DMEM_ARB_RR_EN selects round-robin on ties; otherwise m0 has fixed priority.
module dmem_arb_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

`ifdef DMEM_ARB_RR_EN
    // On a tie, the master that was not granted last time wins.
    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        gnt = req;
        if (req[0]) begin
            gnt = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and access sequencer for the shared single-port data memory.
// Optional round-robin arbitration: define DMEM_ARB_RR_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ACCESS_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(ACCESS_CYC + 1);

    if (ACCESS_CYC < 1) begin : g_bad_access_cyc
        $error("dmem_arbiter: ACCESS_CYC must be at least 1");
    end

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic               owner;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [1:0]         pick_gnt;
    logic               last;
    logic               take;
    logic               capture;

    dmem_arb_pick u_pick (
        .req  ({m1_req, m0_req}),
        .last (last),
        .gnt  (pick_gnt)
    );

`ifdef DMEM_ARB_RR_EN
    // Remembers the most recent winner for round-robin tie breaking.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (take) begin
            last <= pick_gnt[M1];
        end
    end
`else
    assign last = 1'b1;
`endif

    // Next-state logic; take/capture mark the grant and read-capture edges.
    always_comb begin
        state_n = state;
        take    = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (|pick_gnt) begin
                    take    = 1'b1;
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    capture = 1'b1;
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            owner    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            state <= state_n;
            if (take) begin
                owner   <= pick_gnt[M1];
                we_q    <= pick_gnt[M1] ? m1_we    : m0_we;
                addr_q  <= pick_gnt[M1] ? m1_addr  : m0_addr;
                wdata_q <= pick_gnt[M1] ? m1_wdata : m0_wdata;
                cnt     <= CNT_W'(ACCESS_CYC - 1);
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            // Writes report zero as their read data.
            if (capture) begin
                if (owner == 1'(M1)) begin
                    m1_rdata <= we_q ? '0 : mem_rdata;
                end else begin
                    m0_rdata <= we_q ? '0 : mem_rdata;
                end
            end
        end
    end

    // Address/data hold between accesses so only the strobes ever change at the end.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = (state == ACCESS) && !we_q;
    assign mem_write = (state == ACCESS) && we_q;

    assign m0_gnt  = (state == IDLE) && pick_gnt[M0];
    assign m1_gnt  = (state == IDLE) && pick_gnt[M1];
    assign m0_done = (state == RESP) && (owner == 1'(M0));
    assign m1_done = (state == RESP) && (owner == 1'(M1));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench: instance a uses ACCESS_CYC=1, instance b uses ACCESS_CYC=3.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance a signals
    logic        a_m0_req, a_m0_we, a_m1_req, a_m1_we;
    logic [31:0] a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata;
    logic        a_m0_gnt, a_m0_done, a_m1_gnt, a_m1_done;
    logic [31:0] a_m0_rdata, a_m1_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_read, a_mem_write;

    // Instance b signals
    logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
    logic        b_m0_gnt, b_m0_done, b_m1_gnt, b_m1_done;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_read, b_mem_write;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .ACCESS_CYC(1)) dut_a (
        .clk(clk), .rst(rst),
        .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_done(a_m0_done), .m0_rdata(a_m0_rdata),
        .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_done(a_m1_done), .m1_rdata(a_m1_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_rdata(a_mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .ACCESS_CYC(3)) dut_b (
        .clk(clk), .rst(rst),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_done(b_m0_done), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_done(b_m1_done), .m1_rdata(b_m1_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_rdata(b_mem_rdata)
    );

    // Memory model for instance a: asynchronous read, write on the clock edge.
    logic [31:0] mem_a [0:2047];
    always @(posedge clk) begin
        if (rst) begin
            mem_a[1000] <= 32'd10;
            mem_a[1001] <= 32'd20;
        end else if (a_mem_write) begin
            mem_a[a_mem_addr[10:0]] <= a_mem_wdata;
        end
    end
    assign a_mem_rdata = mem_a[a_mem_addr[10:0]];

    // Instance b only needs word 1009 = 100.
    assign b_mem_rdata = (b_mem_addr == 32'd1009) ? 32'd100 : 32'hdead_beef;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    int exp_w;

    initial begin
        rst = 1'b1;
        {a_m0_req, a_m0_we, a_m1_req, a_m1_we} = '0;
        {a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata} = '0;
        {b_m0_req, b_m0_we, b_m1_req, b_m1_we} = '0;
        {b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata} = '0;
        tick();
        tick();

        // Reset state
        check("rst_gnt",   32'({a_m0_gnt, a_m1_gnt}), 32'd0);
        check("rst_done",  32'({a_m0_done, a_m1_done}), 32'd0);
        check("rst_strb",  32'({a_mem_read, a_mem_write}), 32'd0);
        check("rst_addr",  a_mem_addr, 32'd0);
        check("rst_wdata", a_mem_wdata, 32'd0);
        check("rst_rdata", a_m0_rdata | a_m1_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // m0 read of 1000
        a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'd1000;
        settle();
        check("rd0_gnt", 32'({a_m0_gnt, a_m1_gnt}), 32'b10);
        tick();
        a_m0_req = 1'b0;
        settle();
        check("rd0_read",  32'({a_mem_read, a_mem_write}), 32'b10);
        check("rd0_addr",  a_mem_addr, 32'd1000);
        check("rd0_nognt", 32'(a_m0_gnt), 32'd0);
        tick();
        check("rd0_done",  32'({a_m0_done, a_m1_done}), 32'b10);
        check("rd0_rdata", a_m0_rdata, 32'd10);
        check("rd0_strb",  32'({a_mem_read, a_mem_write}), 32'd0);
        tick();
        check("rd0_done_pulse", 32'(a_m0_done), 32'd0);
        check("rd0_rdata_held", a_m0_rdata, 32'd10);

        // m1 write 55 to 1003, then read back
        a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 32'd1003; a_m1_wdata = 32'd55;
        settle();
        check("wr1_gnt", 32'({a_m0_gnt, a_m1_gnt}), 32'b01);
        tick();
        a_m1_req = 1'b0;
        settle();
        check("wr1_strb",  32'({a_mem_read, a_mem_write}), 32'b01);
        check("wr1_wdata", a_mem_wdata, 32'd55);
        tick();
        check("wr1_done",  32'({a_m0_done, a_m1_done}), 32'b01);
        check("wr1_rdata", a_m1_rdata, 32'd0);
        check("wr1_strb_off", 32'(a_mem_write), 32'd0);
        check("wr1_addr_hold", a_mem_addr, 32'd1003);
        tick();
        check("wr1_addr_idle", a_mem_addr, 32'd1003);
        a_m1_req = 1'b1; a_m1_we = 1'b0;
        settle();
        check("rd1_gnt", 32'(a_m1_gnt), 32'd1);
        tick();
        a_m1_req = 1'b0;
        tick();
        check("rd1_done",  32'(a_m1_done), 32'd1);
        check("rd1_rdata", a_m1_rdata, 32'd55);
        tick();

        // Both masters request continuously
        a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'd1000;
        a_m1_req = 1'b1; a_m1_we = 1'b0; a_m1_addr = 32'd1001;
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
            exp_w = i % 2;
`else
            exp_w = 0;
`endif
            settle();
            check($sformatf("tie%0d_gnt", i), 32'({a_m0_gnt, a_m1_gnt}),
                  (exp_w == 0) ? 32'b10 : 32'b01);
            tick();
            tick();
            check($sformatf("tie%0d_done", i), 32'({a_m0_done, a_m1_done}),
                  (exp_w == 0) ? 32'b10 : 32'b01);
            check($sformatf("tie%0d_rdata", i), (exp_w == 0) ? a_m0_rdata : a_m1_rdata,
                  (exp_w == 0) ? 32'd10 : 32'd20);
            check($sformatf("tie%0d_resp_gnt", i), 32'({a_m0_gnt, a_m1_gnt}), 32'd0);
            tick();
        end
        a_m0_req = 1'b0; a_m1_req = 1'b0;
        tick();

        // m0 pulses req during m1's access and is never served
        a_m1_req = 1'b1; a_m1_we = 1'b0; a_m1_addr = 32'd1001;
        settle();
        check("pulse_m1_gnt", 32'(a_m1_gnt), 32'd1);
        tick();
        a_m1_req = 1'b0;
        a_m0_req = 1'b1; a_m0_addr = 32'd1000;
        settle();
        check("pulse_m0_gnt_acc", 32'(a_m0_gnt), 32'd0);
        tick();
        a_m0_req = 1'b0;
        settle();
        check("pulse_m1_done",  32'({a_m0_done, a_m1_done}), 32'b01);
        check("pulse_m1_rdata", a_m1_rdata, 32'd20);
        check("pulse_m0_gnt_resp", 32'(a_m0_gnt), 32'd0);
        tick();
        check("pulse_idle_gnt", 32'({a_m0_gnt, a_m1_gnt}), 32'd0);
        tick();
        check("pulse_idle_strb", 32'({a_mem_read, a_mem_write}), 32'd0);
        tick();
        check("pulse_no_done", 32'({a_m0_done, a_m1_done}), 32'd0);

        // ACCESS_CYC=3: m0 read of 1009
        b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 32'd1009;
        settle();
        check("c3_gnt", 32'(b_m0_gnt), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            b_m0_req = 1'b0;
            check($sformatf("c3_read_t%0d", k), 32'({b_mem_read, b_mem_write}), 32'b10);
            check($sformatf("c3_nodone_t%0d", k), 32'(b_m0_done), 32'd0);
        end
        tick();
        check("c3_done",  32'(b_m0_done), 32'd1);
        check("c3_rdata", b_m0_rdata, 32'd100);
        check("c3_strb",  32'({b_mem_read, b_mem_write}), 32'd0);
        tick();

        // Reset in the second ACCESS cycle of an m1 write
        b_m1_req = 1'b1; b_m1_we = 1'b1; b_m1_addr = 32'd1005; b_m1_wdata = 32'd77;
        settle();
        check("rsta_gnt", 32'(b_m1_gnt), 32'd1);
        tick();
        b_m1_req = 1'b0;
        check("rsta_acc1", 32'(b_mem_write), 32'd1);
        tick();
        check("rsta_acc2", 32'(b_mem_write), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rsta_strb",  32'({b_mem_read, b_mem_write}), 32'd0);
        check("rsta_done",  32'({b_m0_done, b_m1_done}), 32'd0);
        check("rsta_addr",  b_mem_addr, 32'd0);
        check("rsta_wdata", b_mem_wdata, 32'd0);
        check("rsta_rdata", b_m0_rdata | b_m1_rdata, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rsta_quiet%0d", k),
                  32'({b_m1_done, b_mem_write, b_mem_read}), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
